// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    // Arbiter FSM: no owner, owner holds the bus, owner aborted by the watchdog.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    // Watchdog counter width; at least one bit so a disabled watchdog still elaborates.
    function automatic int wd_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of master-side and slave-side Wishbone signals around the arbiter.
// Handshake: a beat transfers on a cycle where cyc & stb & !stall; each
// transferred beat is answered later by exactly one ack or err.
interface wb_arbiter_if import wb_arb_pkg::*; #(
    parameter int NM = 2
);
    // Master side (packed, master k at [W*k +: W])
    logic [NM*WB_AW-1:0] i_m_wb_addr;
    logic [NM*WB_DW-1:0] i_m_wb_data;
    logic [NM*WB_SW-1:0] i_m_wb_sel;
    logic [NM-1:0]       i_m_wb_we;
    logic [NM-1:0]       i_m_wb_cyc;
    logic [NM-1:0]       i_m_wb_stb;
    logic [NM-1:0]       o_m_wb_ack;
    logic [NM*WB_DW-1:0] o_m_wb_data;
    logic [NM-1:0]       o_m_wb_stall;
    logic [NM-1:0]       o_m_wb_err;
    // Slave side, towards the interconnect
    logic [WB_AW-1:0]    o_s_wb_addr;
    logic [WB_DW-1:0]    o_s_wb_data;
    logic [WB_SW-1:0]    o_s_wb_sel;
    logic                o_s_wb_we;
    logic                o_s_wb_cyc;
    logic                o_s_wb_stb;
    logic                i_s_wb_ack;
    logic [WB_DW-1:0]    i_s_wb_data;
    logic                i_s_wb_stall;
    logic                i_s_wb_err;

    // The arbiter's view: slave to the masters, master to the interconnect.
    modport slave (
        input  i_m_wb_addr, i_m_wb_data, i_m_wb_sel, i_m_wb_we, i_m_wb_cyc, i_m_wb_stb,
        output o_m_wb_ack, o_m_wb_data, o_m_wb_stall, o_m_wb_err,
        output o_s_wb_addr, o_s_wb_data, o_s_wb_sel, o_s_wb_we, o_s_wb_cyc, o_s_wb_stb,
        input  i_s_wb_ack, i_s_wb_data, i_s_wb_stall, i_s_wb_err
    );

    // The surroundings' view: bus masters plus interconnect.
    modport master (
        output i_m_wb_addr, i_m_wb_data, i_m_wb_sel, i_m_wb_we, i_m_wb_cyc, i_m_wb_stb,
        input  o_m_wb_ack, o_m_wb_data, o_m_wb_stall, o_m_wb_err,
        input  o_s_wb_addr, o_s_wb_data, o_s_wb_sel, o_s_wb_we, o_s_wb_cyc, o_s_wb_stb,
        output i_s_wb_ack, i_s_wb_data, i_s_wb_stall, i_s_wb_err
    );

endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// Round-robin picker: first requester searching upward from last_owner+1, wrapping.
module rr_picker #(
    parameter int NM = 2
) (
    input  logic [NM-1:0]         i_req,
    input  logic [$clog2(NM)-1:0] i_last,
    output logic [$clog2(NM)-1:0] o_idx,
    output logic                  o_valid
);
    localparam int IW = $clog2(NM);

    logic [IW-1:0] cand;

    // Scan NM candidates starting after the previous owner; the last one tried is the previous owner itself.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        cand    = '0;
        for (int i = 1; i <= NM; i++) begin
            cand = IW'((int'(i_last) + i) % NM);
            if (!o_valid && i_req[cand]) begin
                o_valid = 1'b1;
                o_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter with grant locked for the owner's
// whole CYC and a watchdog that aborts a cycle the slave never answers.
module wb_arbiter import wb_arb_pkg::*; #(
    parameter int NM             = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    wb_arbiter_if.slave   bus,
    output logic [NM-1:0] o_grant,
    output logic          o_timeout,
    output arb_state_t    o_state
);
    localparam int IW  = $clog2(NM);
    localparam int WDW = wd_width(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0] WD_MAX  = '1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    arb_state_t     state_q, state_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  last_q, last_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic [IW-1:0]  pick_idx;
    logic           pick_valid;
    logic           own_cyc;
    logic           s_done;
    logic           wd_fire;

    rr_picker #(.NM(NM)) u_picker (
        .i_req   (bus.i_m_wb_cyc),
        .i_last  (last_q),
        .o_idx   (pick_idx),
        .o_valid (pick_valid)
    );

    assign own_cyc = bus.i_m_wb_cyc[owner_q];
    assign s_done  = bus.i_s_wb_ack | bus.i_s_wb_err;
    // A real slave response on the last allowed cycle beats the watchdog.
    assign wd_fire = (TIMEOUT_CYCLES > 0) && (state_q == OWN) && own_cyc && !s_done
                     && (wd_q == WD_LAST);
    assign o_state = state_q;

    // State, owner, rotation pointer and watchdog registers.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NM - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state logic; the watchdog clears whenever it is not actively counting.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wd_d    = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (s_done) begin
                    wd_d = '0;
                end else if (wd_fire) begin
                    state_d = ABORT;
                end else begin
                    wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
                end
            end
            ABORT: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus steering: only the owner in OWN reaches the slave; everyone else is stalled and silent.
    always_comb begin
        bus.o_s_wb_addr  = '0;
        bus.o_s_wb_data  = '0;
        bus.o_s_wb_sel   = '0;
        bus.o_s_wb_we    = 1'b0;
        bus.o_s_wb_cyc   = 1'b0;
        bus.o_s_wb_stb   = 1'b0;
        bus.o_m_wb_ack   = '0;
        bus.o_m_wb_err   = '0;
        bus.o_m_wb_data  = '0;
        bus.o_m_wb_stall = '1;
        o_grant          = '0;
        o_timeout        = 1'b0;
        if (state_q == OWN) begin
            bus.o_s_wb_addr = bus.i_m_wb_addr[owner_q*WB_AW +: WB_AW];
            bus.o_s_wb_data = bus.i_m_wb_data[owner_q*WB_DW +: WB_DW];
            bus.o_s_wb_sel  = bus.i_m_wb_sel[owner_q*WB_SW +: WB_SW];
            bus.o_s_wb_we   = bus.i_m_wb_we[owner_q];
            bus.o_s_wb_cyc  = own_cyc;
            bus.o_s_wb_stb  = bus.i_m_wb_stb[owner_q];
            bus.o_m_wb_ack[owner_q]   = bus.i_s_wb_ack;
            bus.o_m_wb_err[owner_q]   = bus.i_s_wb_err | wd_fire;
            bus.o_m_wb_stall[owner_q] = bus.i_s_wb_stall;
            bus.o_m_wb_data[owner_q*WB_DW +: WB_DW] = bus.i_s_wb_data;
            o_timeout = wd_fire;
        end
        if (state_q != IDLE) begin
            o_grant[owner_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus pushes expected bus events, a monitor
// pops and compares them whenever grant changes or an ack/err/timeout appears.
module tb_wb_arbiter;
    import wb_arb_pkg::*;

    localparam int NM = 2;
    localparam int TO = 16;
    localparam logic [31:0] KEY = 32'h8000_0015;

    typedef struct packed {
        logic [NM-1:0] grant;
        logic [NM-1:0] ack;
        logic [NM-1:0] err;
        logic          to;
        logic [31:0]   data;
    } ev_t;

    logic          clk;
    logic          rst_n;
    logic [NM-1:0] grant;
    logic          timeout;
    arb_state_t    state;
    logic          slave_en;
    logic          resp_ack, inj_ack;
    logic [31:0]   resp_data, inj_data;
    ev_t           exp_q[$];
    int            checks;
    int            failures;

    wb_arbiter_if #(.NM(NM)) bus();

    wb_arbiter #(.NM(NM), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk     (clk),
        .i_resetn  (rst_n),
        .bus       (bus),
        .o_grant   (grant),
        .o_timeout (timeout),
        .o_state   (state)
    );

    assign bus.i_s_wb_ack  = resp_ack | inj_ack;
    assign bus.i_s_wb_data = resp_ack ? resp_data : (inj_ack ? inj_data : 32'h0);

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [NM-1:0] onehot(input int m);
        logic [NM-1:0] v;
        v = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    function automatic ev_t mk(input logic [NM-1:0] g, input logic [NM-1:0] a,
                               input logic [NM-1:0] e, input logic t, input logic [31:0] d);
        ev_t v;
        v.grant = g; v.ack = a; v.err = e; v.to = t; v.data = d;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_master(input int m, input logic cyc, input logic stb, input logic [31:0] addr);
        bus.i_m_wb_cyc[m]          = cyc;
        bus.i_m_wb_stb[m]          = stb;
        bus.i_m_wb_addr[m*32 +: 32] = addr;
        bus.i_m_wb_data[m*32 +: 32] = ~addr;
        bus.i_m_wb_sel[m*4 +: 4]    = 4'hF;
        bus.i_m_wb_we[m]           = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Called on the cycle where master m first sees its grant; runs n back-to-back
    // beats, optionally raising the other master at beat raise_k, then drops cyc.
    task automatic burst(input int m, input logic [31:0] base, input int n, input int raise_k);
        for (int k = 0; k < n; k++)
            exp_q.push_back(mk(onehot(m), onehot(m), '0, 1'b0, (base + 32'(4 * k)) ^ KEY));
        for (int k = 0; k < n; k++) begin
            if (k == raise_k) set_master(1 - m, 1'b1, 1'b1, 32'h8000_2000);
            set_master(m, 1'b1, 1'b1, base + 32'(4 * k));
            @(negedge clk);
            chk("burst_grant", 32'(grant), 32'(onehot(m)));
            chk("burst_s_cyc", 32'(bus.o_s_wb_cyc), 1);
            chk("burst_s_stb", 32'(bus.o_s_wb_stb), 1);
            chk("burst_s_addr", bus.o_s_wb_addr, base + 32'(4 * k));
            chk("burst_owner_stall", 32'(bus.o_m_wb_stall[m]), 0);
            chk("burst_other_stall", 32'(bus.o_m_wb_stall[1 - m]), 1);
            step();
        end
        set_master(m, 1'b1, 1'b0, base);
        @(negedge clk);
        chk("burst_tail_s_cyc", 32'(bus.o_s_wb_cyc), 1);
        chk("burst_tail_other_stall", 32'(bus.o_m_wb_stall[1 - m]), 1);
        step();
        set_master(m, 1'b0, 1'b0, 32'h0);
    endtask

    // slave responder: one-cycle registered ack for every accepted strobe
    initial begin
        logic        take;
        logic [31:0] a;
        resp_ack  = 1'b0;
        resp_data = 32'h0;
        forever begin
            @(negedge clk);
            take = slave_en && bus.o_s_wb_cyc && bus.o_s_wb_stb && !bus.i_s_wb_stall;
            a    = bus.o_s_wb_addr;
            @(posedge clk);
            #1;
            resp_ack  = take;
            resp_data = take ? (a ^ KEY) : 32'h0;
        end
    end

    // monitor / scoreboard
    initial begin
        ev_t           obs, e;
        logic [NM-1:0] prev_g;
        prev_g = '0;
        forever begin
            @(negedge clk);
            obs.grant = grant;
            obs.ack   = bus.o_m_wb_ack;
            obs.err   = bus.o_m_wb_err;
            obs.to    = timeout;
            obs.data  = 32'h0;
            if (|bus.o_m_wb_ack)
                for (int m = 0; m < NM; m++) obs.data = obs.data | bus.o_m_wb_data[m*32 +: 32];
            if (grant != prev_g || |obs.ack || |obs.err || obs.to) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: got grant=%b ack=%b err=%b to=%b data=0x%0h, none expected",
                             obs.grant, obs.ack, obs.err, obs.to, obs.data);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        failures++;
                        $display("FAIL event: got grant=%b ack=%b err=%b to=%b data=0x%0h expected grant=%b ack=%b err=%b to=%b data=0x%0h",
                                 obs.grant, obs.ack, obs.err, obs.to, obs.data,
                                 e.grant, e.ack, e.err, e.to, e.data);
                    end
                end
            end
            prev_g = grant;
        end
    end

    // stimulus
    initial begin
        int o;
        checks   = 0;
        failures = 0;
        slave_en = 1'b1;
        inj_ack  = 1'b0;
        inj_data = 32'h0;
        bus.i_m_wb_addr  = '0;
        bus.i_m_wb_data  = '0;
        bus.i_m_wb_sel   = '0;
        bus.i_m_wb_we    = '0;
        bus.i_m_wb_cyc   = '0;
        bus.i_m_wb_stb   = '0;
        bus.i_s_wb_stall = 1'b0;
        bus.i_s_wb_err   = 1'b0;
        rst_n = 1'b0;

        // reset values
        step();
        step();
        @(negedge clk);
        chk("rst_s_bus", 32'({bus.o_s_wb_cyc, bus.o_s_wb_stb, bus.o_s_wb_we, bus.o_s_wb_sel}), 0);
        chk("rst_s_addr", bus.o_s_wb_addr | bus.o_s_wb_data, 0);
        chk("rst_m_stall", 32'(bus.o_m_wb_stall), 32'h3);
        chk("rst_m_ack_err", 32'({bus.o_m_wb_ack, bus.o_m_wb_err}), 0);
        chk("rst_m_data", bus.o_m_wb_data[31:0] | bus.o_m_wb_data[63:32], 0);
        chk("rst_grant_to", 32'({grant, timeout}), 0);
        chk("rst_state", 32'(state), 32'(IDLE));
        step();
        rst_n = 1'b1;
        step();

        // single CPU read: stalled first cycle, granted next, data 0x15 returned
        set_master(0, 1'b1, 1'b1, 32'h8000_0000);
        exp_q.push_back(mk(2'b01, '0, '0, 1'b0, 32'h0));
        @(negedge clk);
        chk("single_first_stall", 32'(bus.o_m_wb_stall[0]), 1);
        chk("single_idle_s_cyc", 32'(bus.o_s_wb_cyc), 0);
        step();
        burst(0, 32'h8000_0000, 1, -1);
        exp_q.push_back(mk(2'b00, '0, '0, 1'b0, 32'h0));
        @(negedge clk);
        chk("single_grant_held", 32'(grant), 32'h1);
        step();
        @(negedge clk);
        chk("single_grant_released", 32'(grant), 0);
        step();

        // contention from reset: m0 first, then strict alternation with one dead cycle
        do_reset();
        set_master(0, 1'b1, 1'b1, 32'h8000_0100);
        set_master(1, 1'b1, 1'b1, 32'h8000_0200);
        exp_q.push_back(mk(2'b01, '0, '0, 1'b0, 32'h0));
        @(negedge clk);
        chk("contend_both_stalled", 32'(bus.o_m_wb_stall), 32'h3);
        step();
        o = 0;
        for (int r = 0; r < 4; r++) begin
            burst(o, 32'h8000_0000 + 32'(r * 256) + 32'(o * 16), 2, -1);
            exp_q.push_back(mk(2'b00, '0, '0, 1'b0, 32'h0));
            if (r < 3) exp_q.push_back(mk(onehot(1 - o), '0, '0, 1'b0, 32'h0));
            else set_master(1 - o, 1'b0, 1'b0, 32'h0);
            step();
            if (r < 3) set_master(o, 1'b1, 1'b1, 32'h8000_0300);
            @(negedge clk);
            chk("contend_dead_grant", 32'(grant), 0);
            chk("contend_dead_s_cyc", 32'(bus.o_s_wb_cyc), 0);
            step();
            o = 1 - o;
        end
        step();

        // lock: m1 requests during m0's 8-beat burst and waits it out
        do_reset();
        set_master(0, 1'b1, 1'b1, 32'h8000_1000);
        exp_q.push_back(mk(2'b01, '0, '0, 1'b0, 32'h0));
        step();
        burst(0, 32'h8000_1000, 8, 2);
        exp_q.push_back(mk(2'b00, '0, '0, 1'b0, 32'h0));
        exp_q.push_back(mk(2'b10, '0, '0, 1'b0, 32'h0));
        step();
        @(negedge clk);
        chk("lock_dead_m1_stall", 32'(bus.o_m_wb_stall[1]), 1);
        step();
        burst(1, 32'h8000_2000, 1, -1);
        exp_q.push_back(mk(2'b00, '0, '0, 1'b0, 32'h0));
        step();
        step();

        // watchdog: slave silent, err + timeout on the 16th OWN cycle
        do_reset();
        slave_en = 1'b0;
        set_master(0, 1'b1, 1'b1, 32'h8000_3000);
        exp_q.push_back(mk(2'b01, '0, '0, 1'b0, 32'h0));
        exp_q.push_back(mk(2'b01, '0, 2'b01, 1'b1, 32'h0));
        step();
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k == TO || k == TO - 1) begin
                chk("wd_timeout", 32'(timeout), 32'(k == TO));
                chk("wd_err", 32'(bus.o_m_wb_err[0]), 32'(k == TO));
            end
            step();
            if (k == 1) set_master(0, 1'b1, 1'b0, 32'h8000_3000);
        end
        inj_ack  = 1'b1;
        inj_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wd_abort_state", 32'(state), 32'(ABORT));
        chk("wd_abort_s_cyc", 32'(bus.o_s_wb_cyc), 0);
        chk("wd_abort_stall", 32'(bus.o_m_wb_stall[0]), 1);
        chk("wd_late_ack_dropped", 32'(bus.o_m_wb_ack[0]), 0);
        step();
        inj_ack  = 1'b0;
        slave_en = 1'b1;
        set_master(1, 1'b1, 1'b1, 32'h8000_4000);
        set_master(0, 1'b0, 1'b0, 32'h0);
        exp_q.push_back(mk(2'b00, '0, '0, 1'b0, 32'h0));
        exp_q.push_back(mk(2'b10, '0, '0, 1'b0, 32'h0));
        step();
        step();
        burst(1, 32'h8000_4000, 1, -1);
        exp_q.push_back(mk(2'b00, '0, '0, 1'b0, 32'h0));
        step();
        step();

        // ack on the 16th cycle wins and restarts the count: next timeout at cycle 32
        do_reset();
        slave_en = 1'b0;
        set_master(0, 1'b1, 1'b1, 32'h8000_5000);
        exp_q.push_back(mk(2'b01, '0, '0, 1'b0, 32'h0));
        exp_q.push_back(mk(2'b01, 2'b01, '0, 1'b0, 32'h0000_0777));
        exp_q.push_back(mk(2'b01, '0, 2'b01, 1'b1, 32'h0));
        step();
        for (int k = 1; k <= 2 * TO; k++) begin
            @(negedge clk);
            if (k == TO) begin
                chk("ackto_ack", 32'(bus.o_m_wb_ack[0]), 1);
                chk("ackto_no_err", 32'({bus.o_m_wb_err[0], timeout}), 0);
            end
            if (k == TO + 1) chk("ackto_restart_no_to", 32'(timeout), 0);
            if (k == 2 * TO) chk("ackto_second_to", 32'(timeout), 1);
            step();
            if (k == 1) set_master(0, 1'b1, 1'b0, 32'h8000_5000);
            if (k == TO - 1) begin
                inj_ack  = 1'b1;
                inj_data = 32'h0000_0777;
            end
            if (k == TO) inj_ack = 1'b0;
        end
        set_master(0, 1'b0, 1'b0, 32'h0);
        exp_q.push_back(mk(2'b00, '0, '0, 1'b0, 32'h0));
        step();
        step();

        // asynchronous reset in the middle of an owned cycle
        do_reset();
        set_master(0, 1'b1, 1'b1, 32'h8000_6000);
        exp_q.push_back(mk(2'b01, '0, '0, 1'b0, 32'h0));
        step();
        step();
        exp_q.push_back(mk(2'b00, '0, '0, 1'b0, 32'h0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_s_cyc", 32'({bus.o_s_wb_cyc, bus.o_s_wb_stb}), 0);
        chk("async_grant", 32'(grant), 0);
        set_master(1, 1'b1, 1'b1, 32'h8000_7000);
        step();
        step();
        rst_n = 1'b1;
        exp_q.push_back(mk(2'b01, '0, '0, 1'b0, 32'h0));
        step();
        @(negedge clk);
        chk("async_m0_first", 32'(grant), 32'h1);
        step();
        set_master(0, 1'b0, 1'b0, 32'h0);
        set_master(1, 1'b0, 1'b0, 32'h0);
        exp_q.push_back(mk(2'b00, '0, '0, 1'b0, 32'h0));
        step();
        step();
        step();

        // anything still expected never appeared
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event: got nothing expected grant=%b ack=%b err=%b to=%b data=0x%0h",
                     e.grant, e.ack, e.err, e.to, e.data);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
